// File: rtl/disp_mem_arbiter.sv
// Single-port display memory arbiter: the VGA scan owns the port during active video.
// Game-logic reads/writes and the clear sweep share the blanking cycles.
module disp_mem_arbiter #(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 3,
    parameter int                NUM_WORDS   = 300,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = {DATA_W{1'b0}}
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iBLANK_n,
    input  logic [ADDR_W-1:0] iVGA_ADDR,
    output logic [DATA_W-1:0] oVGA_DATA,
    input  logic              iWR_REQ,
    input  logic [ADDR_W-1:0] iWR_ADDR,
    input  logic [DATA_W-1:0] iWR_DATA,
    output logic              oWR_ACK,
    input  logic              iRD_REQ,
    input  logic [ADDR_W-1:0] iRD_ADDR,
    output logic              oRD_ACK,
    output logic [DATA_W-1:0] oRD_DATA,
    output logic              oRD_VALID,
    input  logic              iCLEAR,
    output logic              oBUSY,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic [DATA_W-1:0] oMEM_WDATA,
    output logic              oMEM_WE,
    input  logic [DATA_W-1:0] iMEM_RDATA
);

    localparam logic [ADDR_W-1:0] NUM_WORDS_A = ADDR_W'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_CLEAR
    } state_t;

    state_t            state_reg, state_next;
    logic              last_rd_reg, last_rd_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic              clr_pend_reg, clr_pend_next;
    logic              rd_oob_reg, rd_oob_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    logic              wr_ack;
    logic              rd_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg    <= S_IDLE;
            last_rd_reg  <= 1'b1;
            clr_cnt_reg  <= '0;
            clr_pend_reg <= 1'b0;
            rd_oob_reg   <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_rd_reg  <= last_rd_next;
            clr_cnt_reg  <= clr_cnt_next;
            clr_pend_reg <= clr_pend_next;
            rd_oob_reg   <= rd_oob_next;
            rd_valid_reg <= (state_reg == S_RD_WAIT);
            // Capture is unconditional on blanking: the address was presented in the grant cycle.
            if (state_reg == S_RD_WAIT) begin
                rd_data_reg <= rd_oob_reg ? CLEAR_COLOR : iMEM_RDATA;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_rd_next  = last_rd_reg;
        clr_cnt_next  = clr_cnt_reg;
        clr_pend_next = clr_pend_reg;
        rd_oob_next   = rd_oob_reg;
        mem_addr      = iVGA_ADDR;
        mem_wdata     = iWR_DATA;
        mem_we        = 1'b0;
        wr_ack        = 1'b0;
        rd_ack        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (iCLEAR || clr_pend_reg) begin
                    state_next    = S_CLEAR;
                    clr_cnt_next  = '0;
                    clr_pend_next = 1'b0;
                end else if (!iBLANK_n) begin
                    // Round-robin between the two request classes when both are pending.
                    if (iWR_REQ && (!iRD_REQ || last_rd_reg)) begin
                        wr_ack       = 1'b1;
                        mem_addr     = iWR_ADDR;
                        mem_wdata    = iWR_DATA;
                        mem_we       = (iWR_ADDR < NUM_WORDS_A);
                        last_rd_next = 1'b0;
                    end else if (iRD_REQ) begin
                        rd_ack       = 1'b1;
                        mem_addr     = iRD_ADDR;
                        last_rd_next = 1'b1;
                        rd_oob_next  = !(iRD_ADDR < NUM_WORDS_A);
                        state_next   = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (iCLEAR) begin
                    clr_pend_next = 1'b1;
                end
                state_next = S_IDLE;
            end
            S_CLEAR: begin
                if (!iBLANK_n) begin
                    mem_addr  = clr_cnt_reg;
                    mem_wdata = CLEAR_COLOR;
                    mem_we    = 1'b1;
                    if (clr_cnt_reg == LAST_ADDR) begin
                        state_next   = S_IDLE;
                        clr_cnt_next = '0;
                    end else begin
                        clr_cnt_next = clr_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Strobes are gated by reset so nothing reaches the memory while iRST_n is low.
    assign oWR_ACK    = wr_ack && iRST_n;
    assign oRD_ACK    = rd_ack && iRST_n;
    assign oMEM_WE    = mem_we && iRST_n;
    assign oMEM_ADDR  = mem_addr;
    assign oMEM_WDATA = mem_wdata;
    assign oVGA_DATA  = iMEM_RDATA;
    assign oRD_DATA   = rd_data_reg;
    assign oRD_VALID  = rd_valid_reg;
    assign oBUSY      = (state_reg == S_CLEAR);

endmodule
